// File: rtl/pcie_turnoff_ctrl.sv
// pcie_turnoff_ctrl: multi-channel PCIe turn-off controller.
// Per-channel saturating counters track outstanding completions. On
// PME_Turn_Off the FSM raises trn_hold_o, waits for every counter to drain,
// then acknowledges on cfg_turnoff_ok_n_o until the request is released.
// Optional feature macro: PCIE_TURNOFF_TMO_EN (adds a drain timeout).
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | normal operation, no turn-off request
//   DRAIN | turn-off requested, hold asserted, waiting for counters
//   ACK   | drained (or timed out), turn-off acknowledged

module pcie_turnoff_ctrl #(
  parameter int G_CH_COUNT = 2,
  parameter int G_PEND_W   = 4,
  parameter int G_TMO_W    = 16,
  parameter logic [G_TMO_W-1:0] G_TMO_VAL = 16'hFFFF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [G_CH_COUNT-1:0]          req_compl_i,
  input  logic [G_CH_COUNT-1:0]          compl_done_i,
  input  logic                           cfg_to_turnoff_n_i,
  output logic                           cfg_turnoff_ok_n_o,
  output logic                           trn_hold_o,
  output logic                           pend_any_o,
  output logic [G_CH_COUNT*G_PEND_W-1:0] pend_cnt_o,
  output logic                           err_ovf_o,
  output logic                           err_unf_o,
  output logic                           tmo_o,
  output logic [1:0]                     state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [G_CH_COUNT*G_PEND_W-1:0]  cnt_q, cnt_d;
  logic [G_PEND_W-1:0]             cur;
  logic                            pend_any_q;
  logic                            ovf_hit, unf_hit;
  logic                            ovf_q, unf_q, tmo_q;
  logic                            tmo_hit;

  // Next value of every pending counter; saturation attempts raise error hits.
  always_comb begin
    cnt_d   = cnt_q;
    cur     = '0;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    for (int i = 0; i < G_CH_COUNT; i++) begin
      cur = cnt_q[i*G_PEND_W +: G_PEND_W];
      if (req_compl_i[i] && !compl_done_i[i]) begin
        if (cur == {G_PEND_W{1'b1}}) ovf_hit = 1'b1;
        else cnt_d[i*G_PEND_W +: G_PEND_W] = cur + 1'b1;
      end else if (compl_done_i[i] && !req_compl_i[i]) begin
        if (cur == '0) unf_hit = 1'b1;
        else cnt_d[i*G_PEND_W +: G_PEND_W] = cur - 1'b1;
      end
    end
  end

`ifdef PCIE_TURNOFF_TMO_EN
  logic [G_TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q == ST_DRAIN) && pend_any_q && (tmo_cnt_q == G_TMO_VAL);

  // Timeout counter: cleared on DRAIN entry, advances every DRAIN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ST_DRAIN && state_d == ST_DRAIN) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_DRAIN) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  // Without the timeout the drain waits indefinitely; the parameters stay
  // in the port list so both builds share one instantiation.
  logic [G_TMO_W-1:0] tmo_val_unused;
  assign tmo_val_unused = G_TMO_VAL;
  assign tmo_hit        = 1'b0;
`endif

  // Next-state logic; withdrawal of the request always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!cfg_to_turnoff_n_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cfg_to_turnoff_n_i)  state_d = ST_IDLE;
        else if (!pend_any_q)    state_d = ST_ACK;
        else if (tmo_hit)        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (cfg_to_turnoff_n_i)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_any_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_any_q <= |cnt_d;
      if (ovf_hit) ovf_q <= 1'b1;
      if (unf_hit) unf_q <= 1'b1;
      if (tmo_hit && !cfg_to_turnoff_n_i) tmo_q <= 1'b1;
    end
  end

  assign cfg_turnoff_ok_n_o = (state_q != ST_ACK);
  assign trn_hold_o         = (state_q == ST_DRAIN) || (state_q == ST_ACK);
  assign pend_any_o         = pend_any_q;
  assign pend_cnt_o         = cnt_q;
  assign err_ovf_o          = ovf_q;
  assign err_unf_o          = unf_q;
  assign tmo_o              = tmo_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_pcie_turnoff_ctrl.sv
// Directed testbench for pcie_turnoff_ctrl (2 channels, 4-bit counters,
// drain timeout of 8 cycles when PCIE_TURNOFF_TMO_EN is defined).

module tb_pcie_turnoff_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_compl_i;
  logic [1:0] compl_done_i;
  logic       cfg_to_turnoff_n_i;
  logic       cfg_turnoff_ok_n_o;
  logic       trn_hold_o;
  logic       pend_any_o;
  logic [7:0] pend_cnt_o;
  logic       err_ovf_o;
  logic       err_unf_o;
  logic       tmo_o;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;

  pcie_turnoff_ctrl #(
    .G_CH_COUNT(2),
    .G_PEND_W(4),
    .G_TMO_W(16),
    .G_TMO_VAL(16'd8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_compl_i(req_compl_i),
    .compl_done_i(compl_done_i),
    .cfg_to_turnoff_n_i(cfg_to_turnoff_n_i),
    .cfg_turnoff_ok_n_o(cfg_turnoff_ok_n_o),
    .trn_hold_o(trn_hold_o),
    .pend_any_o(pend_any_o),
    .pend_cnt_o(pend_cnt_o),
    .err_ovf_o(err_ovf_o),
    .err_unf_o(err_unf_o),
    .tmo_o(tmo_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_compl_i = 2'b00;
    compl_done_i = 2'b00;
    cfg_to_turnoff_n_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One-cycle strobes on both channel inputs.
  task automatic strobe(input logic [1:0] req, input logic [1:0] done);
    req_compl_i = req;
    compl_done_i = done;
    tick();
    req_compl_i = 2'b00;
    compl_done_i = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cfg_turnoff_ok_n_o !== 1'b1) begin errors++; $display("FAIL reset_ok_n: got %b want 1", cfg_turnoff_ok_n_o); end
    checks++; if (trn_hold_o !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", trn_hold_o); end
    checks++; if (pend_any_o !== 1'b0) begin errors++; $display("FAIL reset_pend_any: got %b want 0", pend_any_o); end
    checks++; if (pend_cnt_o !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h want 00", pend_cnt_o); end
    checks++; if ({err_ovf_o, err_unf_o, tmo_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {err_ovf_o, err_unf_o, tmo_o}); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
  endtask

  task automatic test_turnoff_idle();
    do_reset();
    cfg_to_turnoff_n_i = 1'b0;
    tick();
    checks++; if ({state_o, trn_hold_o, cfg_turnoff_ok_n_o} !== {2'd1, 1'b1, 1'b1}) begin errors++; $display("FAIL idle_T: got state=%0d hold=%b ok_n=%b want 1 1 1", state_o, trn_hold_o, cfg_turnoff_ok_n_o); end
    tick();
    checks++; if ({state_o, trn_hold_o, cfg_turnoff_ok_n_o} !== {2'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL idle_T1: got state=%0d hold=%b ok_n=%b want 2 1 0", state_o, trn_hold_o, cfg_turnoff_ok_n_o); end
    tick();
    checks++; if (cfg_turnoff_ok_n_o !== 1'b0) begin errors++; $display("FAIL idle_ack_held: got ok_n=%b want 0", cfg_turnoff_ok_n_o); end
    cfg_to_turnoff_n_i = 1'b1;
    tick();
    checks++; if ({state_o, trn_hold_o, cfg_turnoff_ok_n_o} !== {2'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL idle_release: got state=%0d hold=%b ok_n=%b want 0 0 1", state_o, trn_hold_o, cfg_turnoff_ok_n_o); end
  endtask

  task automatic test_drain();
    do_reset();
    strobe(2'b11, 2'b00);
    strobe(2'b01, 2'b00);
    strobe(2'b01, 2'b00);
    checks++; if ({pend_cnt_o, pend_any_o} !== {8'h13, 1'b1}) begin errors++; $display("FAIL drain_cnt: got cnt=%h any=%b want 13 1", pend_cnt_o, pend_any_o); end
    cfg_to_turnoff_n_i = 1'b0;
    tick(); tick(); tick();
    checks++; if ({state_o, trn_hold_o, cfg_turnoff_ok_n_o} !== {2'd1, 1'b1, 1'b1}) begin errors++; $display("FAIL drain_wait: got state=%0d hold=%b ok_n=%b want 1 1 1", state_o, trn_hold_o, cfg_turnoff_ok_n_o); end
    strobe(2'b00, 2'b11);
    checks++; if (pend_cnt_o !== 8'h02) begin errors++; $display("FAIL drain_dec: got %h want 02", pend_cnt_o); end
    strobe(2'b00, 2'b01);
    strobe(2'b00, 2'b01);
    checks++; if ({pend_cnt_o, pend_any_o, state_o} !== {8'h00, 1'b0, 2'd1}) begin errors++; $display("FAIL drain_last: got cnt=%h any=%b state=%0d want 00 0 1", pend_cnt_o, pend_any_o, state_o); end
    tick();
    checks++; if ({state_o, cfg_turnoff_ok_n_o} !== {2'd2, 1'b0}) begin errors++; $display("FAIL drain_ack: got state=%0d ok_n=%b want 2 0", state_o, cfg_turnoff_ok_n_o); end
    strobe(2'b10, 2'b00);
    checks++; if ({state_o, pend_cnt_o, err_ovf_o, err_unf_o} !== {2'd2, 8'h10, 1'b0, 1'b0}) begin errors++; $display("FAIL ack_req: got state=%0d cnt=%h ovf=%b unf=%b want 2 10 0 0", state_o, pend_cnt_o, err_ovf_o, err_unf_o); end
    cfg_to_turnoff_n_i = 1'b1;
    tick();
    checks++; if ({state_o, trn_hold_o, cfg_turnoff_ok_n_o} !== {2'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL drain_release: got state=%0d hold=%b ok_n=%b want 0 0 1", state_o, trn_hold_o, cfg_turnoff_ok_n_o); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    strobe(2'b01, 2'b00);
    strobe(2'b01, 2'b00);
    strobe(2'b01, 2'b01);
    checks++; if ({pend_cnt_o, err_ovf_o, err_unf_o} !== {8'h02, 1'b0, 1'b0}) begin errors++; $display("FAIL same_cycle: got cnt=%h ovf=%b unf=%b want 02 0 0", pend_cnt_o, err_ovf_o, err_unf_o); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 15; i++) strobe(2'b01, 2'b00);
    checks++; if ({pend_cnt_o, err_ovf_o} !== {8'h0F, 1'b0}) begin errors++; $display("FAIL sat_max: got cnt=%h ovf=%b want 0f 0", pend_cnt_o, err_ovf_o); end
    strobe(2'b01, 2'b00);
    checks++; if ({pend_cnt_o, err_ovf_o, err_unf_o} !== {8'h0F, 1'b1, 1'b0}) begin errors++; $display("FAIL sat_ovf: got cnt=%h ovf=%b unf=%b want 0f 1 0", pend_cnt_o, err_ovf_o, err_unf_o); end
    strobe(2'b00, 2'b10);
    checks++; if ({pend_cnt_o, err_ovf_o, err_unf_o} !== {8'h0F, 1'b1, 1'b1}) begin errors++; $display("FAIL sat_unf: got cnt=%h ovf=%b unf=%b want 0f 1 1", pend_cnt_o, err_ovf_o, err_unf_o); end
    strobe(2'b00, 2'b01);
    tick();
    checks++; if ({pend_cnt_o, err_ovf_o, err_unf_o} !== {8'h0E, 1'b1, 1'b1}) begin errors++; $display("FAIL sat_sticky: got cnt=%h ovf=%b unf=%b want 0e 1 1", pend_cnt_o, err_ovf_o, err_unf_o); end
  endtask

  task automatic test_withdraw();
    do_reset();
    strobe(2'b01, 2'b00);
    cfg_to_turnoff_n_i = 1'b0;
    tick();
    checks++; if ({state_o, trn_hold_o, cfg_turnoff_ok_n_o} !== {2'd1, 1'b1, 1'b1}) begin errors++; $display("FAIL wd_drain: got state=%0d hold=%b ok_n=%b want 1 1 1", state_o, trn_hold_o, cfg_turnoff_ok_n_o); end
    tick();
    checks++; if ({state_o, cfg_turnoff_ok_n_o} !== {2'd1, 1'b1}) begin errors++; $display("FAIL wd_stay: got state=%0d ok_n=%b want 1 1", state_o, cfg_turnoff_ok_n_o); end
    cfg_to_turnoff_n_i = 1'b1;
    tick();
    checks++; if ({state_o, trn_hold_o, cfg_turnoff_ok_n_o, pend_cnt_o} !== {2'd0, 1'b0, 1'b1, 8'h01}) begin errors++; $display("FAIL wd_idle: got state=%0d hold=%b ok_n=%b cnt=%h want 0 0 1 01", state_o, trn_hold_o, cfg_turnoff_ok_n_o, pend_cnt_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    strobe(2'b01, 2'b00);
    cfg_to_turnoff_n_i = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) tick();
    checks++; if ({state_o, tmo_o} !== {2'd1, 1'b0}) begin errors++; $display("FAIL tmo_before: got state=%0d tmo=%b want 1 0", state_o, tmo_o); end
    tick();
`ifdef PCIE_TURNOFF_TMO_EN
    checks++; if ({state_o, tmo_o, cfg_turnoff_ok_n_o, pend_cnt_o} !== {2'd2, 1'b1, 1'b0, 8'h01}) begin errors++; $display("FAIL tmo_fire: got state=%0d tmo=%b ok_n=%b cnt=%h want 2 1 0 01", state_o, tmo_o, cfg_turnoff_ok_n_o, pend_cnt_o); end
    cfg_to_turnoff_n_i = 1'b1;
    tick();
    checks++; if ({state_o, tmo_o} !== {2'd0, 1'b1}) begin errors++; $display("FAIL tmo_sticky: got state=%0d tmo=%b want 0 1", state_o, tmo_o); end
`else
    for (int i = 0; i < 20; i++) tick();
    checks++; if ({state_o, tmo_o, cfg_turnoff_ok_n_o} !== {2'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL tmo_absent: got state=%0d tmo=%b ok_n=%b want 1 0 1", state_o, tmo_o, cfg_turnoff_ok_n_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_turnoff_idle();
    test_drain();
    test_same_cycle();
    test_saturate();
    test_withdraw();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
